// File: rtl/vita_tx_pkt_checker.sv
// vita_tx_pkt_checker: fifo36 framing/length sanitiser; forwards only well-framed packets through a 1-deep output slot
module vita_tx_pkt_checker #(
  parameter logic [7:0] BASE = 8'd0,
  parameter int LEN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic        err_stb,
  output logic [1:0]  err_code,
  output logic [15:0] drop_count
);
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t state, nxt;
  logic en_r, en_s, en_e, acc, fwd, err, sof, eof;
  logic [LEN_BITS-1:0] max_r, max_s, cnt, cnt_n;
  logic [1:0] code;
  logic [35:0] d;
  logic unused_bits;
  assign unused_bits = ^set_data[31:17];
  assign sof = data_i[32];
  assign eof = data_i[33];
  // a SOF accepted in IDLE starts a packet under the live settings; everything else follows the shadow
  assign en_e = (state == IDLE && sof) ? en_r : en_s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      en_r  <= 1'b1;
      max_r <= LEN_BITS'(1024);
    end else if (set_stb && set_addr == BASE) begin
      en_r  <= set_data[16];
      max_r <= set_data[LEN_BITS-1:0];
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      src_rdy_o  <= 1'b0;
      data_o     <= '0;
      err_stb    <= 1'b0;
      err_code   <= 2'd0;
      drop_count <= 16'd0;
      en_s       <= 1'b1;
      max_s      <= LEN_BITS'(1024);
    end else if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      src_rdy_o  <= 1'b0;
      err_stb    <= 1'b0;
      err_code   <= 2'd0;
      drop_count <= 16'd0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      err_stb <= err;
      if (fwd) begin
        src_rdy_o <= 1'b1;
        data_o    <= d;
      end else if (dst_rdy_i) src_rdy_o <= 1'b0;
      if (err) err_code <= code;
      if (err && ~&drop_count) drop_count <= drop_count + 16'd1;
      if (acc && sof) begin
        en_s  <= en_r;
        max_s <= max_r;
      end
    end
  always_comb begin
    nxt   = state;
    fwd   = 1'b0;
    err   = 1'b0;
    code  = 2'd0;
    cnt_n = cnt;
    d     = data_i;
    if (acc) begin
      if (state == DROP) nxt = eof ? IDLE : DROP;
      else if (!en_e) begin
        fwd = 1'b1;
        nxt = eof ? IDLE : (sof ? PASS : state);
      end else if (state == IDLE) begin
        if (sof) begin
          fwd   = 1'b1;
          cnt_n = LEN_BITS'(1);
          nxt   = eof ? IDLE : PASS;
        end else begin
          err  = 1'b1;
          code = 2'd1;
          nxt  = eof ? IDLE : DROP;
        end
      end else if (sof) begin
        fwd  = 1'b1;
        d    = {2'b00, 1'b1, 1'b0, data_i[31:0]};
        err  = 1'b1;
        code = 2'd3;
        nxt  = eof ? IDLE : DROP;
      end else if (eof) begin
        fwd = 1'b1;
        nxt = IDLE;
      end else begin
        fwd   = 1'b1;
        cnt_n = cnt + 1'b1;
        if (max_s != '0 && cnt_n == max_s) begin
          d    = {2'b00, 1'b1, data_i[32:0]};
          err  = 1'b1;
          code = 2'd2;
          nxt  = DROP;
        end
      end
    end
  end
  always_comb begin
    dst_rdy_o = (state == DROP) | ~src_rdy_o | dst_rdy_i;
    acc       = src_rdy_i & dst_rdy_o;
  end
endmodule

// File: tb/tb_vita_tx_pkt_checker.sv
// tb_vita_tx_pkt_checker: scoreboard bench for the TX framing/length sanitiser
module tb_vita_tx_pkt_checker;
  logic clk = 0, reset = 0, clear = 0, set_stb = 0;
  logic [7:0] set_addr = 0;
  logic [31:0] set_data = 0;
  logic [35:0] data_i = 0;
  logic src_rdy_i = 0, dst_rdy_i = 1;
  logic dst_rdy_o, src_rdy_o, err_stb;
  logic [35:0] data_o;
  logic [1:0] err_code;
  logic [15:0] drop_count;
  int total = 0, bad = 0, outs = 0, errs = 0;
  bit toggle = 0;
  logic [35:0] sb[$];

  vita_tx_pkt_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
    .data_o(data_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i), .err_stb(err_stb),
    .err_code(err_code), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (toggle) begin
    #1 dst_rdy_i = ~dst_rdy_i;
  end

  // output side of the scoreboard: every line that leaves must be the oldest expected one
  always @(negedge clk) begin
    if (err_stb) errs++;
    if (src_rdy_o && dst_rdy_i) begin
      total++;
      outs++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected got=%h want=none", data_o);
      end else begin
        if (data_o !== sb[0]) begin
          bad++;
          $display("FAIL out_line got=%h want=%h", data_o, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  function automatic logic [35:0] mk(input logic s, input logic e, input logic [1:0] o, input logic [31:0] v);
    return {o, e, s, v};
  endfunction

  task automatic send(input logic [35:0] dl, input bit keep, input logic [35:0] ex);
    int n = 0;
    data_i = dl;
    src_rdy_i = 1;
    @(negedge clk);
    while (!dst_rdy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!dst_rdy_o) begin
      bad++;
      $display("FAIL send_accept got=stalled want=accepted line=%h", dl);
    end else if (keep) sb.push_back(ex);
    @(posedge clk);
    #1 src_rdy_i = 0;
  endtask

  task automatic pass(input logic [35:0] dl);
    send(dl, 1, dl);
  endtask

  task automatic drop(input logic [35:0] dl);
    send(dl, 0, '0);
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
  endtask

  task automatic set_reg(input logic en, input logic [15:0] mx);
    set_stb = 1;
    set_addr = 0;
    set_data = {15'd0, en, mx};
    @(posedge clk);
    #1 set_stb = 0;
  endtask

  task automatic pulse_clear;
    clear = 1;
    @(posedge clk);
    #1 clear = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (src_rdy_o !== 1'b0) begin bad++; $display("FAIL rst_src_rdy got=%b want=0", src_rdy_o); end
    if (data_o !== 36'd0) begin bad++; $display("FAIL rst_data got=%h want=0", data_o); end
    if (err_stb !== 1'b0) begin bad++; $display("FAIL rst_err_stb got=%b want=0", err_stb); end
    if (err_code !== 2'd0) begin bad++; $display("FAIL rst_err_code got=%0d want=0", err_code); end
    if (drop_count !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_count); end
    if (dst_rdy_o !== 1'b1) begin bad++; $display("FAIL rst_dst_rdy got=%b want=1", dst_rdy_o); end
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int e0 = errs, o0 = outs;
    logic [35:0] a = mk(1, 0, 0, 32'h1111_0000);
    pass(a);
    total += 2;
    if (src_rdy_o !== 1'b1) begin bad++; $display("FAIL basic_latency_vld got=%b want=1", src_rdy_o); end
    if (data_o !== a) begin bad++; $display("FAIL basic_latency_data got=%h want=%h", data_o, a); end
    pass(mk(0, 0, 0, 32'h1111_0001));
    pass(mk(0, 1, 1, 32'h1111_0002));
    drain();
    total += 2;
    if (outs - o0 != 3) begin bad++; $display("FAIL basic_count got=%0d want=3", outs - o0); end
    if (errs != e0) begin bad++; $display("FAIL basic_err got=%0d want=0", errs - e0); end
  endtask

  task automatic test_back_to_back;
    int e0 = errs, o0 = outs;
    toggle = 1;
    for (int i = 0; i < 20; i++) pass(mk(i == 0, i == 19, 0, 32'hB000_0000 + i));
    drain();
    toggle = 0;
    @(posedge clk);
    #2 dst_rdy_i = 1;
    @(posedge clk);
    #1;
    total += 2;
    if (outs - o0 != 20) begin bad++; $display("FAIL bp_count got=%0d want=20", outs - o0); end
    if (errs != e0) begin bad++; $display("FAIL bp_err got=%0d want=0", errs - e0); end
  endtask

  task automatic test_overlength;
    int e0 = errs;
    logic [35:0] l;
    set_reg(1, 4);
    for (int i = 0; i < 10; i++) begin
      l = mk(i == 0, i == 9, (i == 3) ? 2'd3 : 2'd0, 32'hC000_0000 + i);
      if (i < 3) pass(l);
      else if (i == 3) begin
        send(l, 1, mk(0, 1, 0, 32'hC000_0003));
        total += 2;
        if (err_stb !== 1'b1) begin bad++; $display("FAIL ovl_err_stb got=%b want=1", err_stb); end
        if (err_code !== 2'd2) begin bad++; $display("FAIL ovl_err_code got=%0d want=2", err_code); end
        dst_rdy_i = 0;
      end else drop(l);
    end
    dst_rdy_i = 1;
    for (int i = 0; i < 3; i++) pass(mk(i == 0, i == 2, 0, 32'hC100_0000 + i));
    drain();
    total++;
    if (errs - e0 != 1) begin bad++; $display("FAIL ovl_err_cnt got=%0d want=1", errs - e0); end
  endtask

  task automatic test_orphan;
    pulse_clear();
    set_reg(1, 0);
    drop(mk(0, 0, 0, 32'hD000_0000));
    total += 2;
    if (err_stb !== 1'b1) begin bad++; $display("FAIL orphan_err_stb got=%b want=1", err_stb); end
    if (err_code !== 2'd1) begin bad++; $display("FAIL orphan_err_code got=%0d want=1", err_code); end
    drop(mk(0, 1, 0, 32'hD000_0001));
    total++;
    if (err_stb !== 1'b0) begin bad++; $display("FAIL orphan_drop_err got=%b want=0", err_stb); end
    pass(mk(1, 0, 0, 32'hD100_0000));
    pass(mk(0, 1, 2, 32'hD100_0001));
    drain();
    total++;
    if (drop_count !== 16'd1) begin bad++; $display("FAIL orphan_drop_count got=%0d want=1", drop_count); end
  endtask

  task automatic test_missing_eof;
    pass(mk(1, 0, 0, 32'hA000_0000));
    pass(mk(0, 0, 1, 32'hA000_0001));
    send(mk(1, 0, 3, 32'hB000_0000), 1, mk(0, 1, 0, 32'hB000_0000));
    total++;
    if (err_code !== 2'd3) begin bad++; $display("FAIL meof_err_code got=%0d want=3", err_code); end
    drop(mk(0, 0, 0, 32'hB000_0001));
    drop(mk(0, 1, 0, 32'hB000_0002));
    pass(mk(1, 1, 0, 32'hE000_0000));
    drain();
    total++;
    if (drop_count !== 16'd2) begin bad++; $display("FAIL meof_drop_count got=%0d want=2", drop_count); end
  endtask

  task automatic test_settings_clear;
    int e0 = errs;
    set_reg(1, 8);
    pass(mk(1, 0, 0, 32'hF000_0000));
    pass(mk(0, 0, 0, 32'hF000_0001));
    pass(mk(0, 0, 0, 32'hF000_0002));
    set_reg(1, 3);
    for (int i = 3; i < 7; i++) pass(mk(0, 0, 0, 32'hF000_0000 + i));
    pass(mk(0, 1, 0, 32'hF000_0007));
    drain();
    total++;
    if (errs != e0) begin bad++; $display("FAIL old_limit_err got=%0d want=0", errs - e0); end
    pass(mk(1, 0, 0, 32'hF100_0000));
    pass(mk(0, 0, 0, 32'hF100_0001));
    send(mk(0, 0, 0, 32'hF100_0002), 1, mk(0, 1, 0, 32'hF100_0002));
    total++;
    if (err_code !== 2'd2) begin bad++; $display("FAIL new_limit_err_code got=%0d want=2", err_code); end
    drop(mk(0, 1, 0, 32'hF100_0003));
    pass(mk(1, 0, 0, 32'hF200_0000));
    pass(mk(0, 0, 0, 32'hF200_0001));
    clear = 1;
    drop(mk(0, 0, 0, 32'hF200_0002));
    clear = 0;
    total += 3;
    if (src_rdy_o !== 1'b0) begin bad++; $display("FAIL clear_src_rdy got=%b want=0", src_rdy_o); end
    if (drop_count !== 16'd0) begin bad++; $display("FAIL clear_drop got=%0d want=0", drop_count); end
    if (err_stb !== 1'b0) begin bad++; $display("FAIL clear_err_stb got=%b want=0", err_stb); end
    drain();
    drop(mk(0, 1, 0, 32'hF300_0000));
    total += 2;
    if (err_code !== 2'd1) begin bad++; $display("FAIL clear_orphan_code got=%0d want=1", err_code); end
    if (drop_count !== 16'd1) begin bad++; $display("FAIL clear_orphan_drop got=%0d want=1", drop_count); end
  endtask

  task automatic test_async_reset;
    dst_rdy_i = 0;
    drop(mk(1, 0, 0, 32'h5000_0000));
    #2 reset = 0;
    #1;
    total += 2;
    if (src_rdy_o !== 1'b0) begin bad++; $display("FAIL areset_src_rdy got=%b want=0", src_rdy_o); end
    if (data_o !== 36'd0) begin bad++; $display("FAIL areset_data got=%h want=0", data_o); end
    #1 reset = 1;
    dst_rdy_i = 1;
    @(posedge clk);
    #1;
    drop(mk(0, 1, 0, 32'h5000_0001));
    total += 2;
    if (err_code !== 2'd1) begin bad++; $display("FAIL areset_orphan got=%0d want=1", err_code); end
    if (drop_count !== 16'd1) begin bad++; $display("FAIL areset_drop got=%0d want=1", drop_count); end
  endtask

  task automatic test_saturation;
    pulse_clear();
    data_i = mk(0, 1, 0, 32'h9999_9999);
    src_rdy_i = 1;
    repeat (65534) @(posedge clk);
    #1;
    total++;
    if (drop_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", drop_count); end
    @(posedge clk);
    #1;
    total++;
    if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h want=ffff", drop_count); end
    @(posedge clk);
    #1;
    src_rdy_i = 0;
    total++;
    if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", drop_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overlength();
    test_orphan();
    test_missing_eof();
    test_settings_clear();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
